// File: rtl/fe_argmax_stream.sv
`default_nettype none
// ============================================================================
// Module      : fe_argmax_stream
// Description : Streaming per-frame argmax/argmin over multi-lane beats using
//               a configurable pipelined compare tree and a frame accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module fe_argmax_stream #(
    parameter int                NB_IN     = 16,
    parameter int                NS_IN     = 64,
    parameter int                N_LEVELS  = 6,
    parameter logic [N_LEVELS:0] REGS      = 7'b1001000,
    parameter int                MAX_BEATS = 16,
    parameter int                NB_BEAT   = 4
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      i_vld,
    input  logic                      i_last,
    input  logic [NB_IN*NS_IN-1:0]    i_data,
    input  logic                      i_cfg_min,
    input  logic                      i_cfg_signed,
    output logic                      o_vld,
    output logic [NB_IN-1:0]          o_data_val,
    output logic [NB_BEAT+N_LEVELS-1:0] o_data_pos,
    output logic [NB_BEAT:0]          o_beat_cnt,
    output logic                      o_ovf
);

    localparam int c_POS_W = NB_BEAT + N_LEVELS;
    localparam int c_IDX_W = N_LEVELS;
    localparam logic [NB_BEAT-1:0] c_LAST_BEAT = NB_BEAT'(MAX_BEATS - 1);

    function automatic int f_nodes(input int lvl);
        int n;
        n = NS_IN;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // True when b is strictly better than a; signedness folded into a sign-extended compare.
    function automatic logic f_better(input logic [NB_IN-1:0] a, input logic [NB_IN-1:0] b,
                                      input logic cmin, input logic csgn);
        logic signed [NB_IN:0] sa;
        logic signed [NB_IN:0] sb;
        sa = {csgn & a[NB_IN-1], a};
        sb = {csgn & b[NB_IN-1], b};
        return cmin ? (sb < sa) : (sb > sa);
    endfunction

    // ------------------------------------------------------------------
    // Input-side frame tracking: config is latched on the first beat.
    // ------------------------------------------------------------------
    logic               r_in_busy;
    logic [NB_BEAT-1:0] r_in_cnt;
    logic               r_cfg_min;
    logic               r_cfg_sgn;
    logic               w_cfg_min;
    logic               w_cfg_sgn;

    assign w_cfg_min = r_in_busy ? r_cfg_min : i_cfg_min;
    assign w_cfg_sgn = r_in_busy ? r_cfg_sgn : i_cfg_signed;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_in_busy <= 1'b0;
            r_in_cnt  <= '0;
            r_cfg_min <= 1'b0;
            r_cfg_sgn <= 1'b0;
        end else if (i_vld) begin
            if (!r_in_busy) begin
                r_cfg_min <= i_cfg_min;
                r_cfg_sgn <= i_cfg_signed;
            end
            if (i_last || (r_in_cnt == c_LAST_BEAT)) begin
                r_in_busy <= 1'b0;
                r_in_cnt  <= '0;
            end else begin
                r_in_busy <= 1'b1;
                r_in_cnt  <= r_in_cnt + NB_BEAT'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare tree, level 0 is the raw input beat.
    // ------------------------------------------------------------------
    logic [NB_IN-1:0]   w_v [0:N_LEVELS][0:NS_IN-1];
    logic [c_IDX_W-1:0] w_i [0:N_LEVELS][0:NS_IN-1];
    logic [N_LEVELS:0]  w_vld;
    logic [N_LEVELS:0]  w_last;
    logic [N_LEVELS:0]  w_min;
    logic [N_LEVELS:0]  w_sgn;

    assign w_vld[0]  = i_vld;
    assign w_last[0] = i_last;
    assign w_min[0]  = w_cfg_min;
    assign w_sgn[0]  = w_cfg_sgn;

    for (genvar j = 0; j < NS_IN; j++) begin : g_lane
        assign w_v[0][j] = i_data[j*NB_IN +: NB_IN];
        assign w_i[0][j] = c_IDX_W'(j);
    end

    for (genvar k = 1; k <= N_LEVELS; k++) begin : g_lvl
        localparam int c_NIN  = f_nodes(k - 1);
        localparam int c_NOUT = f_nodes(k);

        if (REGS[k]) begin : g_side_reg
            logic r_vld;
            logic r_last;
            logic r_min;
            logic r_sgn;
            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    r_vld  <= 1'b0;
                    r_last <= 1'b0;
                    r_min  <= 1'b0;
                    r_sgn  <= 1'b0;
                end else begin
                    r_vld  <= w_vld[k-1];
                    r_last <= w_last[k-1];
                    r_min  <= w_min[k-1];
                    r_sgn  <= w_sgn[k-1];
                end
            end
            assign w_vld[k]  = r_vld;
            assign w_last[k] = r_last;
            assign w_min[k]  = r_min;
            assign w_sgn[k]  = r_sgn;
        end else begin : g_side_comb
            assign w_vld[k]  = w_vld[k-1];
            assign w_last[k] = w_last[k-1];
            assign w_min[k]  = w_min[k-1];
            assign w_sgn[k]  = w_sgn[k-1];
        end

        for (genvar j = 0; j < NS_IN; j++) begin : g_node
            if (j < c_NOUT) begin : g_used
                logic [NB_IN-1:0]   w_nv;
                logic [c_IDX_W-1:0] w_ni;

                if (2*j + 1 < c_NIN) begin : g_cmp
                    logic w_take;
                    // Right operand wins only when strictly better, so the lower lane keeps ties.
                    assign w_take = f_better(w_v[k-1][2*j], w_v[k-1][2*j+1],
                                             w_min[k-1], w_sgn[k-1]);
                    assign w_nv = w_take ? w_v[k-1][2*j+1] : w_v[k-1][2*j];
                    assign w_ni = w_take ? w_i[k-1][2*j+1] : w_i[k-1][2*j];
                end else begin : g_pass
                    assign w_nv = w_v[k-1][2*j];
                    assign w_ni = w_i[k-1][2*j];
                end

                if (REGS[k]) begin : g_reg
                    logic [NB_IN-1:0]   r_nv;
                    logic [c_IDX_W-1:0] r_ni;
                    always_ff @(posedge clk or posedge arst) begin
                        if (arst) begin
                            r_nv <= '0;
                            r_ni <= '0;
                        end else if (w_vld[k-1]) begin
                            r_nv <= w_nv;
                            r_ni <= w_ni;
                        end
                    end
                    assign w_v[k][j] = r_nv;
                    assign w_i[k][j] = r_ni;
                end else begin : g_comb
                    assign w_v[k][j] = w_nv;
                    assign w_i[k][j] = w_ni;
                end
            end else begin : g_unused
                assign w_v[k][j] = '0;
                assign w_i[k][j] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame accumulator and result register.
    // ------------------------------------------------------------------
    logic               w_tv;
    logic               w_tlast;
    logic [NB_IN-1:0]   w_tval;
    logic [c_IDX_W-1:0] w_ti;
    logic [NB_BEAT-1:0] w_bidx;
    logic [c_POS_W-1:0] w_tpos;
    logic               w_take;
    logic               w_close;
    logic [NB_IN-1:0]   w_nval;
    logic [c_POS_W-1:0] w_npos;

    logic               r_acc_busy;
    logic [NB_BEAT-1:0] r_bidx;
    logic [NB_IN-1:0]   r_acc_val;
    logic [c_POS_W-1:0] r_acc_pos;
    logic               r_o_vld;
    logic [NB_IN-1:0]   r_o_val;
    logic [c_POS_W-1:0] r_o_pos;
    logic [NB_BEAT:0]   r_o_cnt;
    logic               r_o_ovf;

    assign w_tv    = w_vld[N_LEVELS];
    assign w_tlast = w_last[N_LEVELS];
    assign w_tval  = w_v[N_LEVELS][0];
    assign w_ti    = w_i[N_LEVELS][0];
    assign w_bidx  = r_acc_busy ? r_bidx : '0;
    assign w_tpos  = c_POS_W'(w_bidx) * c_POS_W'(NS_IN) + c_POS_W'(w_ti);
    // An empty accumulator always loads; afterwards the earliest beat keeps ties.
    assign w_take  = !r_acc_busy ||
                     f_better(r_acc_val, w_tval, w_min[N_LEVELS], w_sgn[N_LEVELS]);
    assign w_nval  = w_take ? w_tval : r_acc_val;
    assign w_npos  = w_take ? w_tpos : r_acc_pos;
    assign w_close = w_tlast || (w_bidx == c_LAST_BEAT);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_acc_busy <= 1'b0;
            r_bidx     <= '0;
            r_acc_val  <= '0;
            r_acc_pos  <= '0;
            r_o_vld    <= 1'b0;
            r_o_val    <= '0;
            r_o_pos    <= '0;
            r_o_cnt    <= '0;
            r_o_ovf    <= 1'b0;
        end else begin
            r_o_vld <= 1'b0;
            if (w_tv) begin
                if (w_close) begin
                    r_o_vld    <= 1'b1;
                    r_o_val    <= w_nval;
                    r_o_pos    <= w_npos;
                    r_o_cnt    <= {1'b0, w_bidx} + (NB_BEAT+1)'(1);
                    r_o_ovf    <= !w_tlast;
                    r_acc_busy <= 1'b0;
                    r_bidx     <= '0;
                end else begin
                    r_acc_busy <= 1'b1;
                    r_acc_val  <= w_nval;
                    r_acc_pos  <= w_npos;
                    r_bidx     <= w_bidx + NB_BEAT'(1);
                end
            end
        end
    end

    assign o_vld      = r_o_vld;
    assign o_data_val = r_o_val;
    assign o_data_pos = r_o_pos;
    assign o_beat_cnt = r_o_cnt;
    assign o_ovf      = r_o_ovf;

endmodule
`default_nettype wire

// File: doc/fe_argmax_stream.md
FE_ARGMAX_STREAM -- requirements
Module: fe_argmax_stream

Interface
REQ-001 SHALL have parameter NB_IN, default 16: lane width in bits.
REQ-002 SHALL have parameter NS_IN, default 64: lanes per beat, any value >= 2, non-power-of-2 allowed.
REQ-003 SHALL have parameter N_LEVELS, default 6: tree depth, equal to ceil(log2(NS_IN)).
REQ-004 SHALL have parameter REGS, default 7'b1001000: bit k=1 registers tree level k (k=1..N_LEVELS); bit 0 ignored.
REQ-005 SHALL have parameter MAX_BEATS, default 16: maximum beats per frame.
REQ-006 SHALL have parameter NB_BEAT, default 4: beat-counter width, with 2^NB_BEAT >= MAX_BEATS.
REQ-007 SHALL have ports: clk in 1, rising-edge clock; arst in 1, asynchronous active-high reset.
REQ-008 SHALL have ports: i_vld in 1 beat valid; i_last in 1 last beat of frame; i_data in NB_IN*NS_IN lanes, lane j at bits [(j+1)*NB_IN-1 : j*NB_IN].
REQ-009 SHALL have ports: i_cfg_min in 1 (1=argmin, 0=argmax); i_cfg_signed in 1 (1=two's complement compare).
REQ-010 SHALL have ports: o_vld out 1; o_data_val out NB_IN; o_data_pos out NB_BEAT+N_LEVELS, global index; o_beat_cnt out NB_BEAT+1; o_ovf out 1.

Function
REQ-011 SHALL accept a beat on every cycle with i_vld=1; no backpressure.
REQ-012 SHALL latch i_cfg_min/i_cfg_signed on the first beat of each frame and apply them to all beats of that frame; mid-frame config changes take effect at the next frame.
REQ-013 SHALL reduce each beat with a binary compare tree: node j of level k compares nodes 2j and 2j+1 of level k-1; an unpaired last node passes through unchanged.
REQ-014 SHALL break ties in favour of the lower lane index, i.e. the right operand wins only if strictly better.
REQ-015 SHALL give the tree a latency of L = number of set bits in REGS[N_LEVELS:1] cycles, and SHALL carry valid, last and config alongside the data through the same pipeline.
REQ-016 SHALL treat the frame accumulator as empty at frame start: the first tree result loads it, and later results replace it only if strictly better, so the earliest beat wins ties.
REQ-017 SHALL compute global position = beat_index*NS_IN + local lane; beat_index starts at 0 and increments per tree-output beat.
REQ-018 SHALL close a frame on a tree-output beat with last=1, or on the MAX_BEATS-th beat if last=0 there.
REQ-019 SHALL, on frame close, register the final result and assert o_vld for exactly 1 cycle, L+1 cycles after the closing i_vld beat; o_beat_cnt = beats in the frame (1..MAX_BEATS).
REQ-020 SHALL set o_ovf=1 with o_vld when a frame was closed by MAX_BEATS without last; o_ovf=0 otherwise.
REQ-021 SHALL hold o_data_val/o_data_pos/o_beat_cnt/o_ovf stable between o_vld pulses.
REQ-022 SHALL support back-to-back frames: a beat arriving the cycle after a closing beat starts a fresh accumulator, with no gap or merge.
REQ-023 SHALL treat a beat with i_vld=1 and i_last=1 as a complete single-beat frame.
REQ-024 SHALL ignore i_data/i_last when i_vld=0; idle cycles inside a frame SHALL neither advance the beat counter nor disturb the accumulator.

Reset
REQ-025 SHALL, while arst=1, immediately clear all pipeline valids, tree registers, accumulator, beat counter and frame state, and drive all outputs to 0.
REQ-026 SHALL discard any in-flight or partially accumulated frame on reset and emit no o_vld for it; the first beat after reset release starts a new frame.

Verification (NB_IN=8, NS_IN=5, N_LEVELS=3, REGS=4'b0100 so L=1, MAX_BEATS=4, NB_BEAT=2)
REQ-027 SHALL test unsigned max, single beat: lanes [3,9,9,1,2], last=1 at cycle t -> o_vld at t+2, val=9, pos=1, beat_cnt=1, ovf=0.
REQ-028 SHALL test compare modes on one beat [5,0xF0,0x80,7,0]: signed min -> val=0x80, pos=2; unsigned max -> val=0xF0, pos=1; signed max -> val=7, pos=3.
REQ-029 SHALL test a 3-beat max frame with 0x40 at beat0 lane3 and beat2 lane3, all other lanes < 0x40 -> val=0x40, pos=3, beat_cnt=3.
REQ-030 SHALL test back-to-back frames, beat A(last) then beat B(last) on consecutive cycles -> two consecutive o_vld pulses, each with its own result and beat_cnt=1.
REQ-031 SHALL test overflow: 4 beats with no last, max 0x7F at beat3 lane4 -> o_vld with pos=19, beat_cnt=4, ovf=1.
REQ-032 SHALL test reset mid-frame: arst pulsed after 2 beats of a frame -> no o_vld; a following 1-beat frame reports beat_cnt=1, pos within 0..4.
